// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared constants and helpers for the NoC ejection endpoint.
//                Default flit layout (LSB first): payload, dest X, dest Y,
//                sequence tag in the MSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Default field widths of the flit
    localparam int DATA_WIDTH  = 32;
    localparam int X_SIZE      = 2;
    localparam int Y_SIZE      = 2;
    localparam int PCK_NUM     = 4;
    localparam int TOTAL_WIDTH = DATA_WIDTH + X_SIZE + Y_SIZE + PCK_NUM;

    // Field offsets for the default layout
    localparam int PAYLOAD_LSB = 0;
    localparam int DX_LSB      = PAYLOAD_LSB + DATA_WIDTH;
    localparam int DY_LSB      = DX_LSB + X_SIZE;
    localparam int SEQ_LSB     = DY_LSB + Y_SIZE;

    // Status counter width
    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : noc_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                always presented on o_dout; o_empty qualifies it.
//  Ports       : clk, rst (async, active-high)
//                i_push / i_din  - write side (ignored when full)
//                i_pop  / o_dout - read side  (ignored when empty)
//                o_full, o_empty - registered occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; stale contents are never visible while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule : noc_rx_fifo
`default_nettype wire

// File: rtl/noc_rx_eject.sv
`default_nettype none
// ============================================================================
//  Module      : noc_rx_eject
//  Description : NoC ejection endpoint. Accepts flits from the switch local
//                port, drops misrouted flits, tracks the per-flow sequence
//                tag, buffers payloads and streams them to the PCI host side.
//  Ports       : clk, rst (async, active-high)
//                i_data/i_valid/o_ready          - switch side handshake
//                o_data_pci/o_valid_pci/i_ready_pci - PCI stream (FWFT)
//                o_rx_count, o_misroute_count, o_seq_err_count - saturating
//                status counters
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_rx_eject
    import noc_pkg::*;
#(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int data_width  = DATA_WIDTH,
    parameter int x_size      = X_SIZE,
    parameter int y_size      = Y_SIZE,
    parameter int pck_num     = PCK_NUM,
    parameter int total_width = data_width + x_size + y_size + pck_num,
    parameter int DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [data_width-1:0]  o_data_pci,
    output logic                   o_valid_pci,
    input  logic                   i_ready_pci,
    output logic [CNT_W-1:0]       o_rx_count,
    output logic [CNT_W-1:0]       o_misroute_count,
    output logic [CNT_W-1:0]       o_seq_err_count
);

    // Field offsets for this instance's layout
    localparam int c_DX_LSB  = data_width;
    localparam int c_DY_LSB  = c_DX_LSB + x_size;
    localparam int c_SEQ_LSB = c_DY_LSB + y_size;

    localparam logic [x_size-1:0] c_MY_X = x_size'(X);
    localparam logic [y_size-1:0] c_MY_Y = y_size'(Y);

    logic [data_width-1:0] w_payload;
    logic [x_size-1:0]     w_dx;
    logic [y_size-1:0]     w_dy;
    logic [pck_num-1:0]    w_tag;
    logic                  w_xfer;
    logic                  w_dest_ok;
    logic                  w_full;
    logic                  w_empty;

    logic                  r_alive;
    logic [pck_num-1:0]    r_exp_seq;
    logic [CNT_W-1:0]      r_rx_cnt;
    logic [CNT_W-1:0]      r_mis_cnt;
    logic [CNT_W-1:0]      r_err_cnt;

    assign w_payload = i_data[data_width-1:0];
    assign w_dx      = i_data[c_DX_LSB +: x_size];
    assign w_dy      = i_data[c_DY_LSB +: y_size];
    assign w_tag     = i_data[c_SEQ_LSB +: pck_num];
    assign w_dest_ok = (w_dx == c_MY_X) && (w_dy == c_MY_Y);

    // r_alive holds o_ready low while reset is active and until the first
    // edge after release; both terms are registered, so the PCI side never
    // reaches o_ready combinationally.
    assign o_ready = r_alive & ~w_full;
    assign w_xfer  = i_valid & o_ready;

    assign o_valid_pci      = ~w_empty;
    assign o_rx_count       = r_rx_cnt;
    assign o_misroute_count = r_mis_cnt;
    assign o_seq_err_count  = r_err_cnt;

    noc_rx_fifo #(
        .WIDTH (data_width),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_xfer & w_dest_ok),
        .i_pop   (i_ready_pci),
        .i_din   (w_payload),
        .o_dout  (o_data_pci),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive   <= 1'b0;
            r_exp_seq <= '0;
            r_rx_cnt  <= '0;
            r_mis_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_xfer) begin
                if (!w_dest_ok) begin
                    // Misrouted flits leave the sequence tracker untouched
                    r_mis_cnt <= sat_inc(r_mis_cnt);
                end else begin
                    r_rx_cnt  <= sat_inc(r_rx_cnt);
                    // Resync on mismatch: the next tag is expected to follow
                    // whatever actually arrived.
                    if (w_tag != r_exp_seq) r_err_cnt <= sat_inc(r_err_cnt);
                    r_exp_seq <= w_tag + 1'b1;
                end
            end
        end
    end

endmodule : noc_rx_eject
`default_nettype wire

// File: tb/tb_noc_rx_eject.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_rx_eject
//  Description : Self-checking bench for noc_rx_eject (X=1, Y=2, DEPTH=8)
//                with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_rx_eject;

    localparam int DEPTH = 8;
    localparam int TX    = 1;
    localparam int TY    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_data_pci;
    logic        o_valid_pci;
    logic        i_ready_pci = 1'b0;
    logic [15:0] o_rx_count;
    logic [15:0] o_misroute_count;
    logic [15:0] o_seq_err_count;

    noc_rx_eject #(
        .X     (TX),
        .Y     (TY),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_data_pci       (o_data_pci),
        .o_valid_pci      (o_valid_pci),
        .i_ready_pci      (i_ready_pci),
        .o_rx_count       (o_rx_count),
        .o_misroute_count (o_misroute_count),
        .o_seq_err_count  (o_seq_err_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mq[$];
    int          m_exp;
    int          m_rx, m_mis, m_err;
    bit          m_alive;
    bit          m_acc;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [39:0] flit(input int tag, input int dy, input int dx,
                                         input logic [31:0] p);
        logic [3:0] t4;
        logic [1:0] y2, x2;
        t4 = tag[3:0];
        y2 = dy[1:0];
        x2 = dx[1:0];
        return {t4, y2, x2, p};
    endfunction

    // One clock of stimulus; called right after a negedge, returns at the
    // next negedge with the model advanced by the transfers of that edge.
    task automatic drive(input logic v, input logic [39:0] d, input logic r);
        bit pop;
        int tag;
        i_valid     = v;
        i_data      = d;
        i_ready_pci = r;
        m_acc = v && m_alive && (mq.size() < DEPTH);
        pop   = r && (mq.size() > 0);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (m_acc) begin
            if ((d[33:32] != TX[1:0]) || (d[35:34] != TY[1:0])) begin
                if (m_mis < 65535) m_mis++;
            end else begin
                mq.push_back(d[31:0]);
                if (m_rx < 65535) m_rx++;
                tag = int'(d[39:36]);
                if (tag != m_exp && m_err < 65535) m_err++;
                m_exp = (tag + 1) % 16;
            end
        end
        m_alive = !rst;
        @(negedge clk);
    endtask

    task automatic model_clear();
        mq.delete();
        m_exp = 0; m_rx = 0; m_mis = 0; m_err = 0;
        m_alive = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready_pci = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", o_ready);
        else n_pass++;
        n_checks++;
        if (o_valid_pci !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid_pci);
        else n_pass++;
        n_checks++;
        if ({o_rx_count, o_misroute_count, o_seq_err_count} !== 48'd0)
            $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0",
                     o_rx_count, o_misroute_count, o_seq_err_count);
        else n_pass++;
        @(negedge clk);
        do_reset();
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", o_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, flit(i, TY, TX, 32'hA0 + 32'(i)), 1'b1);
            n_checks++;
            if (o_valid_pci !== 1'b1 || o_data_pci !== 32'hA0 + 32'(i))
                $display("FAIL basic_data[%0d] got=%b/%h exp=1/%h", i, o_valid_pci,
                         o_data_pci, 32'hA0 + 32'(i));
            else n_pass++;
        end
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if (o_valid_pci !== 1'b0 || o_rx_count !== 16'd3 || o_misroute_count !== 16'd0 ||
            o_seq_err_count !== 16'd0)
            $display("FAIL basic_counts got=v%b rx%0d mis%0d err%0d exp=v0 rx3 mis0 err0",
                     o_valid_pci, o_rx_count, o_misroute_count, o_seq_err_count);
        else n_pass++;
    endtask

    task automatic test_misroute();
        do_reset();
        drive(1'b1, flit(0, 2, 0, 32'hBAD), 1'b1);
        n_checks++;
        if (o_valid_pci !== 1'b0 || o_misroute_count !== 16'd1 || o_rx_count !== 16'd0)
            $display("FAIL misroute_drop got=v%b mis%0d rx%0d exp=v0 mis1 rx0",
                     o_valid_pci, o_misroute_count, o_rx_count);
        else n_pass++;
        // Tag 0 must still be the expected one
        drive(1'b1, flit(0, TY, TX, 32'hC0), 1'b1);
        n_checks++;
        if (o_valid_pci !== 1'b1 || o_data_pci !== 32'hC0 || o_seq_err_count !== 16'd0)
            $display("FAIL misroute_seq got=v%b d%h err%0d exp=v1 dC0 err0",
                     o_valid_pci, o_data_pci, o_seq_err_count);
        else n_pass++;
    endtask

    task automatic test_seq_err();
        int tags[4] = '{0, 1, 3, 4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, flit(tags[i], TY, TX, 32'h100 + 32'(i)), 1'b1);
            n_checks++;
            if (o_valid_pci !== 1'b1 || o_data_pci !== 32'h100 + 32'(i))
                $display("FAIL seq_deliver[%0d] got=%b/%h exp=1/%h", i, o_valid_pci,
                         o_data_pci, 32'h100 + 32'(i));
            else n_pass++;
        end
        n_checks++;
        if (o_seq_err_count !== 16'd1 || o_rx_count !== 16'd4)
            $display("FAIL seq_err_count got=err%0d rx%0d exp=err1 rx4",
                     o_seq_err_count, o_rx_count);
        else n_pass++;
        // 5..15 then wrap to 0: no new errors
        for (int t = 5; t <= 16; t++) drive(1'b1, flit(t % 16, TY, TX, 32'(t)), 1'b1);
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if (o_seq_err_count !== 16'd1 || o_rx_count !== 16'd16)
            $display("FAIL seq_wrap got=err%0d rx%0d exp=err1 rx16",
                     o_seq_err_count, o_rx_count);
        else n_pass++;
    endtask

    task automatic test_full();
        int k;
        logic [31:0] got[$];
        do_reset();
        k = 0;
        for (int c = 0; c < 12; c++) begin
            drive(k < 10, flit(k, TY, TX, 32'hF00 + 32'(k)), 1'b0);
            if (m_acc) k++;
            n_checks++;
            if (o_ready !== (k < 8))
                $display("FAIL full_ready[%0d] got=%b exp=%b", c, o_ready, k < 8);
            else n_pass++;
        end
        for (int c = 0; c < 16; c++) begin
            if (o_valid_pci === 1'b1) got.push_back(o_data_pci);
            drive(k < 10, flit(k, TY, TX, 32'hF00 + 32'(k)), 1'b1);
            if (m_acc) k++;
        end
        n_checks++;
        if (got.size() != 10) $display("FAIL full_count got=%0d exp=10", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_checks++;
            if (got[i] !== 32'hF00 + 32'(i))
                $display("FAIL full_order[%0d] got=%h exp=%h", i, got[i], 32'hF00 + 32'(i));
            else n_pass++;
        end
        n_checks++;
        if (o_rx_count !== 16'd10 || o_seq_err_count !== 16'd0)
            $display("FAIL full_counts got=rx%0d err%0d exp=rx10 err0",
                     o_rx_count, o_seq_err_count);
        else n_pass++;
    endtask

    task automatic test_simul();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, flit(i, TY, TX, 32'h500 + 32'(i)), 1'b0);
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (o_ready !== 1'b1 || o_valid_pci !== 1'b1 || o_data_pci !== 32'h500 + 32'(c))
                $display("FAIL simul[%0d] got=r%b v%b d%h exp=r1 v1 d%h", c, o_ready,
                         o_valid_pci, o_data_pci, 32'h500 + 32'(c));
            else n_pass++;
            drive(1'b1, flit(4 + c, TY, TX, 32'h500 + 32'(4 + c)), 1'b1);
        end
        n = 0;
        for (int c = 0; c < 10 && o_valid_pci === 1'b1; c++) begin
            n++;
            drive(1'b0, '0, 1'b1);
        end
        n_checks++;
        if (n != 4) $display("FAIL simul_occupancy got=%0d exp=4", n);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, flit(i, TY, TX, 32'h900 + 32'(i)), 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid_pci !== 1'b0 || o_ready !== 1'b0 ||
            {o_rx_count, o_misroute_count, o_seq_err_count} !== 48'd0)
            $display("FAIL async_reset got=v%b r%b rx%0d mis%0d err%0d exp=v0 r0 0 0 0",
                     o_valid_pci, o_ready, o_rx_count, o_misroute_count, o_seq_err_count);
        else n_pass++;
        model_clear();
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid_pci !== 1'b0)
            $display("FAIL async_release got=r%b v%b exp=r1 v0", o_ready, o_valid_pci);
        else n_pass++;
        drive(1'b1, flit(0, TY, TX, 32'h77), 1'b1);
        n_checks++;
        if (o_valid_pci !== 1'b1 || o_data_pci !== 32'h77 || o_seq_err_count !== 16'd0 ||
            o_rx_count !== 16'd1)
            $display("FAIL async_first got=v%b d%h err%0d rx%0d exp=v1 d77 err0 rx1",
                     o_valid_pci, o_data_pci, o_seq_err_count, o_rx_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        v;
        logic [39:0] d;
        logic        r;
        int          tag, dx, dy;
        do_reset();
        v = 1'b0;
        d = '0;
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (o_ready !== (mq.size() < DEPTH) || o_valid_pci !== (mq.size() > 0))
                $display("FAIL rand_flags[%0d] got=r%b v%b exp=r%b v%b", c, o_ready,
                         o_valid_pci, mq.size() < DEPTH, mq.size() > 0);
            else n_pass++;
            if (mq.size() > 0) begin
                n_checks++;
                if (o_data_pci !== mq[0])
                    $display("FAIL rand_data[%0d] got=%h exp=%h", c, o_data_pci, mq[0]);
                else n_pass++;
            end
            n_checks++;
            if (o_rx_count !== 16'(m_rx) || o_misroute_count !== 16'(m_mis) ||
                o_seq_err_count !== 16'(m_err))
                $display("FAIL rand_counts[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                         o_rx_count, o_misroute_count, o_seq_err_count, m_rx, m_mis, m_err);
            else n_pass++;
            // A stalled flit is held unchanged until accepted
            if (!(v && !m_acc)) begin
                v   = ($urandom % 4) != 0;
                tag = (($urandom % 6) == 0) ? int'($urandom % 16) : m_exp;
                dx  = (($urandom % 8) == 0) ? int'($urandom % 4) : TX;
                dy  = (($urandom % 8) == 0) ? int'($urandom % 4) : TY;
                d   = flit(tag, dy, dx, $urandom);
            end
            r = (c % 100 < 50) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            drive(v, d, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misroute();
        test_seq_err();
        test_full();
        test_simul();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_noc_rx_eject
`default_nettype wire
